// File: rtl/attr_interp_pkg.sv
// Shared types and helpers for the multi-channel barycentric interpolator.
// Widths: numerator sum NUMW = ATTR_WIDTH+WEIGHT_WIDTH+2, denominator DENW = WEIGHT_WIDTH+2.
package attr_interp_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_e;

  // Widest intermediate the generic helpers handle; NUMW+1 must not exceed it.
  localparam int MAXW = 128;

  function automatic int numw(input int aw, input int ww);
    return aw + ww + 2;
  endfunction

  function automatic int denw(input int ww);
    return ww + 2;
  endfunction

  // Sign-extend the low w bits of v to MAXW bits.
  function automatic logic [MAXW-1:0] sext(input logic [MAXW-1:0] v, input int w);
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

  // Largest positive value representable in w signed bits.
  function automatic logic signed [MAXW-1:0] max_of(input int w);
    return $signed((MAXW'(1) << (w - 1)) - MAXW'(1));
  endfunction

  // True when v does not fit in w signed bits.
  function automatic logic out_of_range(input logic signed [MAXW-1:0] v, input int w);
    return (v > max_of(w)) || (v < ~max_of(w));
  endfunction

  // Clamp v to the w-bit signed range (result still MAXW bits wide).
  function automatic logic signed [MAXW-1:0] sat_clamp(input logic signed [MAXW-1:0] v,
                                                       input int w);
    if (v > max_of(w)) return max_of(w);
    if (v < ~max_of(w)) return ~max_of(w);
    return v;
  endfunction

endpackage

// File: rtl/attribute_interpolator_mc_if.sv
// Fragment-in / result-out handshake bundle of attribute_interpolator_mc.
interface attribute_interpolator_mc_if #(
  parameter int NUM_ATTR     = 4,
  parameter int ATTR_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 21
);
  logic                           i_valid;
  logic                           o_ready;
  logic [NUM_ATTR*ATTR_WIDTH-1:0] i_attr0;
  logic [NUM_ATTR*ATTR_WIDTH-1:0] i_attr1;
  logic [NUM_ATTR*ATTR_WIDTH-1:0] i_attr2;
  logic [WEIGHT_WIDTH-1:0]        i_lambda0;
  logic [WEIGHT_WIDTH-1:0]        i_lambda1;
  logic [WEIGHT_WIDTH-1:0]        i_lambda2;
  logic                           o_valid;
  logic                           i_ready;
  logic [NUM_ATTR*ATTR_WIDTH-1:0] o_attr;
  logic                           o_div_zero;
  logic [NUM_ATTR-1:0]            o_sat;

  modport slave (
    input  i_valid, i_attr0, i_attr1, i_attr2, i_lambda0, i_lambda1, i_lambda2, i_ready,
    output o_ready, o_valid, o_attr, o_div_zero, o_sat
  );

  modport master (
    output i_valid, i_attr0, i_attr1, i_attr2, i_lambda0, i_lambda1, i_lambda2, i_ready,
    input  o_ready, o_valid, o_attr, o_div_zero, o_sat
  );
endinterface

// File: rtl/attr_serial_div.sv
// Single-channel restoring divider on magnitudes: one quotient bit per cycle,
// NW cycles after start; done is high in the last cycle with the signed quotient valid.
module attr_serial_div #(
  parameter int NW = 55,
  parameter int DW = 23,
  parameter int QW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NW-1:0]        num_mag,
  input  logic [DW-1:0]        den_mag,
  input  logic                 neg,
  output logic                 done,
  output logic signed [QW-1:0] quot
);
  localparam int CW = $clog2(NW);

  logic [NW-1:0] quo_q, quo_d, quo_nx;
  logic [DW-1:0] rem_q, rem_d, rem_nx;
  logic [DW-1:0] den_q, den_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [DW:0]   rem_sh, rem_sub;
  logic          ge;
  logic [NW:0]   mag;

  // One restoring step, plus load/step control for the iteration registers.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    rem_sh  = {rem_q, quo_q[NW-1]};
    rem_sub = rem_sh - {1'b0, den_q};
    ge      = rem_sh >= {1'b0, den_q};
    rem_nx  = ge ? DW'(rem_sub) : DW'(rem_sh);
    quo_nx  = {quo_q[NW-2:0], ge};

    done = busy_q && (cnt_q == '0);
    mag  = {1'b0, quo_nx};
    // Negating the magnitude quotient truncates toward zero, like SV "/".
    quot = QW'(neg_q ? -$signed(mag) : $signed(mag));

    if (start) begin
      quo_d  = num_mag;
      rem_d  = '0;
      den_d  = den_mag;
      neg_d  = neg;
      cnt_d  = CW'(NW - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d  = quo_nx;
      rem_d  = rem_nx;
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != '0);
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/attribute_interpolator_mc.sv
// Multi-channel barycentric attribute interpolator:
//   o_attr[k] = (a0*l0 + a1*l1 + a2*l2) / (l0+l1+l2), one fragment in flight.
// Optional macro ATTR_INTERP_SAT_EN: clamp out-of-range quotients and flag o_sat;
// otherwise quotients wrap to ATTR_WIDTH bits and o_sat is 0.
module attribute_interpolator_mc
  import attr_interp_pkg::*;
#(
  parameter int NUM_ATTR     = 4,
  parameter int ATTR_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 21
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  attribute_interpolator_mc_if.slave bus
);
  localparam int NUMW = numw(ATTR_WIDTH, WEIGHT_WIDTH);
  localparam int DENW = denw(WEIGHT_WIDTH);
  localparam int PW   = ATTR_WIDTH + WEIGHT_WIDTH;
  localparam int VW   = NUM_ATTR * ATTR_WIDTH;
`ifdef ATTR_INTERP_SAT_EN
  localparam int QW = NUMW + 1;
`else
  localparam int QW = ATTR_WIDTH;
`endif

  state_e                  state_q, state_d;
  logic [VW-1:0]           attr0_q, attr0_d, attr1_q, attr1_d, attr2_q, attr2_d;
  logic [WEIGHT_WIDTH-1:0] lam0_q, lam0_d, lam1_q, lam1_d, lam2_q, lam2_d;
  logic [VW-1:0]           o_attr_q, o_attr_d;
  logic                    div_zero_q, div_zero_d;
`ifdef ATTR_INTERP_SAT_EN
  logic [NUM_ATTR-1:0]     sat_q, sat_d;
`endif

  logic                    div_start;
  logic [NUM_ATTR-1:0]     div_done;
  logic [NUMW-1:0]         num_mag [NUM_ATTR];
  logic                    num_neg [NUM_ATTR];
  logic signed [QW-1:0]    quot    [NUM_ATTR];
  logic [DENW-1:0]         den_mag;
  logic                    den_neg, den_zero;

  // Multiply-accumulate on the captured fragment; the dividers register its result.
  always_comb begin
    logic signed [PW-1:0]   l0, l1, l2, a0, a1, a2;
    logic signed [DENW-1:0] den;
    logic signed [NUMW-1:0] num;
    l0 = PW'(sext(MAXW'(lam0_q), WEIGHT_WIDTH));
    l1 = PW'(sext(MAXW'(lam1_q), WEIGHT_WIDTH));
    l2 = PW'(sext(MAXW'(lam2_q), WEIGHT_WIDTH));
    den = DENW'(l0) + DENW'(l1) + DENW'(l2);
    den_zero = (den == '0);
    den_neg  = den[DENW-1];
    den_mag  = den_neg ? -den : den;
    for (int k = 0; k < NUM_ATTR; k++) begin
      a0 = PW'(sext(MAXW'(attr0_q[k*ATTR_WIDTH +: ATTR_WIDTH]), ATTR_WIDTH));
      a1 = PW'(sext(MAXW'(attr1_q[k*ATTR_WIDTH +: ATTR_WIDTH]), ATTR_WIDTH));
      a2 = PW'(sext(MAXW'(attr2_q[k*ATTR_WIDTH +: ATTR_WIDTH]), ATTR_WIDTH));
      num = NUMW'(a0 * l0) + NUMW'(a1 * l1) + NUMW'(a2 * l2);
      num_neg[k] = num[NUMW-1];
      // Unsigned magnitude, so the most-negative numerator still fits.
      num_mag[k] = num_neg[k] ? -num : num;
    end
  end

  for (genvar k = 0; k < NUM_ATTR; k++) begin : g_div
    attr_serial_div #(.NW(NUMW), .DW(DENW), .QW(QW)) u_div (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .start   (div_start),
      .num_mag (num_mag[k]),
      .den_mag (den_mag),
      .neg     (num_neg[k] ^ den_neg),
      .done    (div_done[k]),
      .quot    (quot[k])
    );
  end

  // Sequencing FSM: capture, MAC, lockstep divide, hold result until taken.
  always_comb begin
    state_d    = state_q;
    attr0_d    = attr0_q;
    attr1_d    = attr1_q;
    attr2_d    = attr2_q;
    lam0_d     = lam0_q;
    lam1_d     = lam1_q;
    lam2_d     = lam2_q;
    o_attr_d   = o_attr_q;
    div_zero_d = div_zero_q;
`ifdef ATTR_INTERP_SAT_EN
    sat_d      = sat_q;
`endif
    div_start  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        attr0_d = bus.i_attr0;
        attr1_d = bus.i_attr1;
        attr2_d = bus.i_attr2;
        lam0_d  = bus.i_lambda0;
        lam1_d  = bus.i_lambda1;
        lam2_d  = bus.i_lambda2;
        state_d = MAC;
      end
      MAC: begin
        div_zero_d = den_zero;
        o_attr_d   = '0;
`ifdef ATTR_INTERP_SAT_EN
        sat_d      = '0;
`endif
        // A zero weight sum never reaches the dividers.
        if (den_zero) state_d = OUT;
        else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: if (&div_done) begin
        for (int k = 0; k < NUM_ATTR; k++) begin
`ifdef ATTR_INTERP_SAT_EN
          o_attr_d[k*ATTR_WIDTH +: ATTR_WIDTH] =
            ATTR_WIDTH'(sat_clamp(MAXW'(quot[k]), ATTR_WIDTH));
          sat_d[k] = out_of_range(MAXW'(quot[k]), ATTR_WIDTH);
`else
          o_attr_d[k*ATTR_WIDTH +: ATTR_WIDTH] = quot[k];
`endif
        end
        state_d = OUT;
      end
      OUT: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured fragment and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      attr0_q    <= '0;
      attr1_q    <= '0;
      attr2_q    <= '0;
      lam0_q     <= '0;
      lam1_q     <= '0;
      lam2_q     <= '0;
      o_attr_q   <= '0;
      div_zero_q <= 1'b0;
`ifdef ATTR_INTERP_SAT_EN
      sat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      attr0_q    <= attr0_d;
      attr1_q    <= attr1_d;
      attr2_q    <= attr2_d;
      lam0_q     <= lam0_d;
      lam1_q     <= lam1_d;
      lam2_q     <= lam2_d;
      o_attr_q   <= o_attr_d;
      div_zero_q <= div_zero_d;
`ifdef ATTR_INTERP_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == OUT);
  assign bus.o_attr     = o_attr_q;
  assign bus.o_div_zero = div_zero_q;
`ifdef ATTR_INTERP_SAT_EN
  assign bus.o_sat      = sat_q;
`else
  assign bus.o_sat      = '0;
`endif
endmodule
